// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage. It reads bytes from a synchronous instruction
// memory and builds one- or two-byte instructions for decode.
// Ports: clk, rst_n (async, active-low).
// Memory side: imem_addr, imem_rd_en and imem_rdata.
// Decode side: instr, imm, instr_valid and instr_ready.
// Control: pc_load, pc_load_addr, pc and halted.
// The optional macro IFU_PERF_CNT_EN adds a fetch_count output, a 16-bit
// saturating count of accepted instructions.
module instr_fetch_unit #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_rd_en,
   input  logic [7:0]        imem_rdata,
   output logic [7:0]        instr,
   output logic [7:0]        imm,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_addr,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [15:0]       fetch_count
`endif
);

   typedef enum logic [2:0] {
      F1, F1W, F2, F2W, OUT, HALT
   } state_e;

   localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [7:0]        instr_q, instr_d;
   logic [7:0]        imm_q, imm_d;
   logic              two_byte;
   logic              redirect;

   assign two_byte = (imem_rdata[7:4] == 4'b1001) ||
                     (imem_rdata[7:4] == 4'b1101);
   assign redirect = pc_load && (state_q != HALT);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      imm_d   = imm_q;
      unique case (state_q)
         F1:  state_d = F1W;
         F1W: begin
            instr_d = imem_rdata;
            imm_d   = 8'h00;
            pc_d    = pc_q + ADDR_W'(1);
            state_d = two_byte ? F2 : OUT;
         end
         F2:  state_d = F2W;
         F2W: begin
            imm_d   = imem_rdata;
            pc_d    = pc_q + ADDR_W'(1);
            state_d = OUT;
         end
         OUT: begin
            if (instr_ready)
               state_d = (instr_q[7:4] == 4'b1111) ? HALT : F1;
         end
         HALT: state_d = HALT;
         default: state_d = F1;
      endcase
      // A redirect wins over everything: any capture planned for this
      // cycle is dropped and a pending halt is cancelled.
      if (redirect) begin
         state_d = F1;
         pc_d    = pc_load_addr;
         instr_d = instr_q;
         imm_d   = imm_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= F1;
         pc_q    <= RST_PC;
         instr_q <= 8'h00;
         imm_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         imm_q   <= imm_d;
      end
   end

   assign imem_addr   = pc_q;
   // State resets to F1, so the strobe is also gated by rst_n. This keeps
   // it low during reset.
   assign imem_rd_en  = rst_n && ((state_q == F1) || (state_q == F2));
   assign instr       = instr_q;
   assign imm         = imm_q;
   assign instr_valid = (state_q == OUT);
   assign pc          = pc_q;
   assign halted      = (state_q == HALT);

`ifdef IFU_PERF_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == OUT) && instr_ready && !pc_load &&
          (cnt_q != 16'hFFFF))
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 16'h0000;
      else        cnt_q <= cnt_d;
   end

   assign fetch_count = cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks of instr_fetch_unit
// against a transaction-level fetch model with a synchronous memory.
module tb_instr_fetch_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] imem_addr;
   logic       imem_rd_en;
   logic [7:0] imem_rdata = 8'h00;
   logic [7:0] instr;
   logic [7:0] imm;
   logic       instr_valid;
   logic       instr_ready = 1'b0;
   logic       pc_load = 1'b0;
   logic [7:0] pc_load_addr = 8'h00;
   logic [7:0] pc;
   logic       halted;
`ifdef IFU_PERF_CNT_EN
   logic [15:0] fetch_count;
`endif

   logic [7:0] mem [256];
   int tests = 0;
   int fails = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   always_ff @(posedge clk)
      if (imem_rd_en) imem_rdata <= mem[imem_addr];

   instr_fetch_unit #(.ADDR_W(8), .RESET_PC(0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_addr    (imem_addr),
      .imem_rd_en   (imem_rd_en),
      .imem_rdata   (imem_rdata),
      .instr        (instr),
      .imm          (imm),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .pc_load      (pc_load),
      .pc_load_addr (pc_load_addr),
      .pc           (pc),
      .halted       (halted)
`ifdef IFU_PERF_CNT_EN
      ,
      .fetch_count  (fetch_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   // Leaves the bench in cycle 0: rst_n just released, before the first edge.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      pc_load = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      #1;
   endtask

   function automatic bit is_two(input logic [7:0] op);
      return (op[7:4] == 4'h9) || (op[7:4] == 4'hD);
   endfunction

   // Transaction-level model state for the random phase.
   int         m_start;
   logic [7:0] m_addr, m_a1, m_nxt, m_imm;
   bit         m_two;
   int         m_lat;
   bit         exp_v, exp_rd;
`ifdef IFU_PERF_CNT_EN
   int         exp_cnt;
`endif

   task automatic model_start(input int at, input logic [7:0] a);
      m_start = at;
      m_addr  = a;
      m_a1    = a + 8'd1;
      m_two   = is_two(mem[a]);
      m_lat   = m_two ? 4 : 2;
      m_imm   = m_two ? mem[m_a1] : 8'h00;
      m_nxt   = m_two ? m_a1 + 8'd1 : m_a1;
   endtask

   initial begin
      foreach (mem[i]) mem[i] = 8'h00;

      // Reset values, including an asynchronous assertion mid-cycle.
      rst_n = 1'b1;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_pc", pc, 0);
      chk("rst_instr", instr, 0);
      chk("rst_imm", imm, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_rden", imem_rd_en, 0);
      chk("rst_halted", halted, 0);

      // One-byte fetch.
      mem[0] = 8'h16;
      instr_ready = 1'b1;
      do_reset();
      chk("b1_rden0", imem_rd_en, 1);
      chk("b1_addr0", imem_addr, 8'h00);
      step();
      chk("b1_valid1", instr_valid, 0);
      step();
      chk("b1_valid2", instr_valid, 1);
      chk("b1_instr", instr, 8'h16);
      chk("b1_imm", imm, 8'h00);
      chk("b1_pc", pc, 8'h01);
      step();
      chk("b1_next_rden", imem_rd_en, 1);
      chk("b1_next_addr", imem_addr, 8'h01);

      // Two-byte fetch.
      mem[0] = 8'h94; mem[1] = 8'h3C; mem[2] = 8'h16;
      do_reset();
      repeat (3) step();
      chk("b2_valid3", instr_valid, 0);
      step();
      chk("b2_valid4", instr_valid, 1);
      chk("b2_instr", instr, 8'h94);
      chk("b2_imm", imm, 8'h3C);
      chk("b2_pc", pc, 8'h02);
      step();
      chk("b2_next_addr", imem_addr, 8'h02);
      chk("b2_next_rden", imem_rd_en, 1);

      // Backpressure in OUT.
      mem[0] = 8'h16; mem[1] = 8'h27;
      instr_ready = 1'b0;
      do_reset();
      repeat (2) step();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", instr_valid, 1);
         chk("bp_instr", instr, 8'h16);
         chk("bp_imm", imm, 8'h00);
         chk("bp_rden", imem_rd_en, 0);
         chk("bp_pc", pc, 8'h01);
         if (i < 4) step();
      end
      instr_ready = 1'b1;
      step();
      chk("bp_rel_valid", instr_valid, 0);
      chk("bp_rel_rden", imem_rd_en, 1);
      chk("bp_rel_addr", imem_addr, 8'h01);

      // Halt, redirect ignored in HALT, reset clears it.
      mem[0] = 8'h16; mem[1] = 8'hF0;
      do_reset();
      repeat (5) step();
      chk("h_valid", instr_valid, 1);
      chk("h_instr", instr, 8'hF0);
      step();
      chk("h_halted", halted, 1);
      chk("h_valid0", instr_valid, 0);
      pc_load = 1'b1; pc_load_addr = 8'h40;
      for (int i = 0; i < 3; i++) begin
         chk("h_rden", imem_rd_en, 0);
         chk("h_pc", pc, 8'h02);
         step();
      end
      chk("h_still", halted, 1);
      pc_load = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("h_rst_halted", halted, 0);
      chk("h_rst_pc", pc, 8'h00);

      // Redirect colliding with a handshake of a pending HLT.
      mem[0] = 8'hF3; mem[8'h80] = 8'h25;
      do_reset();
      repeat (2) step();
      chk("rc_valid", instr_valid, 1);
      pc_load = 1'b1; pc_load_addr = 8'h80;
      step();
      pc_load = 1'b0;
      chk("rc_pc", pc, 8'h80);
      chk("rc_valid0", instr_valid, 0);
      chk("rc_halted", halted, 0);
      chk("rc_rden", imem_rd_en, 1);
      chk("rc_addr", imem_addr, 8'h80);
      repeat (2) step();
      chk("rc_instr", instr, 8'h25);
      chk("rc_pc2", pc, 8'h81);

      // Redirect while in F2W suppresses the immediate capture.
      mem[0] = 8'h94; mem[1] = 8'h3C; mem[8'h50] = 8'h16;
      do_reset();
      repeat (3) step();
      pc_load = 1'b1; pc_load_addr = 8'h50;
      step();
      pc_load = 1'b0;
      chk("rf_pc", pc, 8'h50);
      chk("rf_imm", imm, 8'h00);
      chk("rf_valid", instr_valid, 0);
      repeat (2) step();
      chk("rf_instr", instr, 8'h16);
      chk("rf_pc2", pc, 8'h51);

      // Wrap: two-byte instruction at 0xFF takes its immediate from 0x00.
      mem[8'hFF] = 8'hD8; mem[0] = 8'h55;
      instr_ready = 1'b0;
      do_reset();
      pc_load = 1'b1; pc_load_addr = 8'hFF;
      step();
      pc_load = 1'b0;
      chk("w_addr", imem_addr, 8'hFF);
      repeat (2) step();
      chk("w_addr2", imem_addr, 8'h00);
      chk("w_rden2", imem_rd_en, 1);
      repeat (2) step();
      chk("w_valid", instr_valid, 1);
      chk("w_instr", instr, 8'hD8);
      chk("w_imm", imm, 8'h55);
      chk("w_pc", pc, 8'h01);
`ifdef IFU_PERF_CNT_EN
      chk("w_cnt0", fetch_count, 0);
`endif
      instr_ready = 1'b1;
      step();
`ifdef IFU_PERF_CNT_EN
      chk("w_cnt1", fetch_count, 1);
`endif

      // Randomized run against the transaction-level model.
      foreach (mem[i]) begin
         mem[i] = 8'($urandom);
         if (mem[i][7:4] == 4'hF) mem[i] = mem[i] ^ 8'h80;
      end
      do_reset();
      model_start(0, 8'h00);
`ifdef IFU_PERF_CNT_EN
      exp_cnt = 0;
`endif
      for (int k = 0; k < 2000; k++) begin
         exp_v  = (cyc >= m_start + m_lat);
         exp_rd = (cyc == m_start) || (m_two && cyc == m_start + 2);
         chk("r_valid", instr_valid, exp_v);
         chk("r_rden", imem_rd_en, exp_rd);
         chk("r_halted", halted, 0);
         if (exp_rd)
            chk("r_addr", imem_addr, (cyc == m_start) ? m_addr : m_a1);
         if (exp_v) begin
            chk("r_instr", instr, mem[m_addr]);
            chk("r_imm", imm, m_imm);
            chk("r_pc", pc, m_nxt);
         end
`ifdef IFU_PERF_CNT_EN
         chk("r_cnt", fetch_count, exp_cnt);
`endif
         instr_ready  = ($urandom_range(0, 3) != 0);
         pc_load      = ($urandom_range(0, 15) == 0);
         pc_load_addr = 8'($urandom);
         if (pc_load)
            model_start(cyc + 1, pc_load_addr);
         else if (exp_v && instr_ready) begin
`ifdef IFU_PERF_CNT_EN
            exp_cnt++;
`endif
            model_start(cyc + 1, m_nxt);
         end
         step();
      end
      pc_load = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
